// File: rtl/search_arbiter.sv
// ---------------------------------------------------------------------------
// search_arbiter
//
// Shares one binary-search engine between N_REQ requesters. A round-robin
// grant picks a requester, its target is latched and presented to the
// engine, the engine result (or a timeout abort) is returned with a
// one-cycle ack to that requester, and the engine is allowed to fall back
// to idle (done low) before the next grant.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no search active; grant round-robin when any req is high
// RUN   | eng_start high, waiting for eng_done or timeout
// RESP  | one-cycle ack to the granted requester, result registers valid
// DRAIN | wait for the engine to drop eng_done before the next grant
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   req_i          level request per requester, held until its ack
//   target_i       packed targets, requester i at [i*A_W +: A_W]
//   ack_o          one-hot, one-cycle pulse when a result is valid
//   res_found_o    found flag of the last completed search
//   res_err_o      timeout flag of the last completed search
//   res_index_o    index of the last completed search
//   busy_o         high whenever the FSM is not in IDLE
//   eng_start_o    start level to the engine (high only in RUN)
//   eng_a_o        latched target value to the engine
//   eng_done_i     engine completion, held while start stays high
//   eng_found_i    engine found flag
//   eng_index_i    engine result index
// ---------------------------------------------------------------------------
module search_arbiter #(
    parameter int N_REQ   = 4,
    parameter int A_W     = 8,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*A_W-1:0]   target_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic                   res_found_o,
    output logic                   res_err_o,
    output logic [ADDR_W-1:0]      res_index_o,
    output logic                   busy_o,
    output logic                   eng_start_o,
    output logic [A_W-1:0]         eng_a_o,
    input  logic                   eng_done_i,
    input  logic                   eng_found_i,
    input  logic [ADDR_W-1:0]      eng_index_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT_0      = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [A_W-1:0]      eng_a_q;
    logic                eng_start_q;
    logic [N_REQ-1:0]    ack_q;
    logic                res_found_q;
    logic                res_err_q;
    logic [ADDR_W-1:0]   res_index_q;
    logic                busy_q;

    logic                grant_vld_d;
    logic [IDX_W-1:0]    grant_idx_d;

    logic [A_W-1:0]      target_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_target
        assign target_arr[gi] = target_i[gi*A_W +: A_W];
    end

    // Round-robin: scan from last_grant+1 upward with wrap, first high req wins.
    // The requester granted last is scanned last, which re-queues it behind
    // everyone else still pending.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_w;
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = IDX_W'(idx);
            if (!grant_vld_d && req_i[idx_w]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = idx_w;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            cnt_q        <= '0;
            eng_a_q      <= '0;
            eng_start_q  <= 1'b0;
            ack_q        <= '0;
            res_found_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_index_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= '0;
                    // Never start while the engine still reports done; it
                    // must have returned to idle first.
                    if (grant_vld_d && !eng_done_i) begin
                        grant_q     <= grant_idx_d;
                        eng_a_q     <= target_arr[grant_idx_d];
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_RUN;
                    end
                end

                S_RUN: begin
                    // A done on the terminal-count cycle still wins.
                    if (eng_done_i) begin
                        res_found_q <= eng_found_i;
                        res_index_q <= eng_index_i;
                        res_err_q   <= 1'b0;
                        eng_start_q <= 1'b0;
                        ack_q       <= ONE_HOT_0 << grant_q;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        res_found_q <= 1'b0;
                        res_index_q <= '0;
                        res_err_q   <= 1'b1;
                        eng_start_q <= 1'b0;
                        ack_q       <= ONE_HOT_0 << grant_q;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_RESP: begin
                    ack_q        <= '0;
                    last_grant_q <= grant_q;
                    state_q      <= S_DRAIN;
                end

                S_DRAIN: begin
                    if (!eng_done_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    eng_start_q <= 1'b0;
                    ack_q       <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign res_found_o = res_found_q;
    assign res_err_o   = res_err_q;
    assign res_index_o = res_index_q;
    assign busy_o      = busy_q;
    assign eng_start_o = eng_start_q;
    assign eng_a_o     = eng_a_q;

endmodule

// File: tb/tb_search_arbiter.sv
// ---------------------------------------------------------------------------
// tb_search_arbiter
//
// Directed bench for search_arbiter (N_REQ=4, A_W=8, ADDR_W=5, TIMEOUT=8).
// The engine is driven cycle by cycle from the scenario tasks. Inputs are
// changed and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_search_arbiter;

    localparam int N_REQ   = 4;
    localparam int A_W     = 8;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*A_W-1:0]   target;
    logic [N_REQ-1:0]       ack;
    logic                   res_found;
    logic                   res_err;
    logic [ADDR_W-1:0]      res_index;
    logic                   busy;
    logic                   eng_start;
    logic [A_W-1:0]         eng_a;
    logic                   eng_done;
    logic                   eng_found;
    logic [ADDR_W-1:0]      eng_index;

    int n_cmp  = 0;
    int n_fail = 0;

    search_arbiter #(
        .N_REQ   (N_REQ),
        .A_W     (A_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .target_i    (target),
        .ack_o       (ack),
        .res_found_o (res_found),
        .res_err_o   (res_err),
        .res_index_o (res_index),
        .busy_o      (busy),
        .eng_start_o (eng_start),
        .eng_a_o     (eng_a),
        .eng_done_i  (eng_done),
        .eng_found_i (eng_found),
        .eng_index_i (eng_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({busy, eng_start, ack, res_found, res_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000000", {busy, eng_start, ack, res_found, res_err});
        end
        n_cmp++;
        if (eng_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_eng_a: got %h want 00", eng_a);
        end
        n_cmp++;
        if (res_index !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_res_index: got %0d want 0", res_index);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        n_cmp++;
        if ({busy, eng_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_req: got busy/start %b want 00", {busy, eng_start});
        end
    endtask

    task automatic test_single();
        target = '0;
        target[7:0] = 8'h2A;
        req = 4'b0001;
        tick(); // c1
        n_cmp++;
        if ({eng_start, busy, ack} !== 6'b110000) begin
            n_fail++;
            $display("FAIL single_c1_ctrl: got start/busy/ack %b want 110000", {eng_start, busy, ack});
        end
        n_cmp++;
        if (eng_a !== 8'h2A) begin
            n_fail++;
            $display("FAIL single_c1_eng_a: got %h want 2a", eng_a);
        end
        tick(); // c2
        tick(); // c3
        target[7:0] = 8'h55;
        tick(); // c4
        tick(); // c5
        n_cmp++;
        if (eng_a !== 8'h2A) begin
            n_fail++;
            $display("FAIL single_eng_a_stable: got %h want 2a", eng_a);
        end
        n_cmp++;
        if ({eng_start, ack} !== 5'b10000) begin
            n_fail++;
            $display("FAIL single_c5_ctrl: got start/ack %b want 10000", {eng_start, ack});
        end
        tick(); // c6
        eng_done  = 1'b1;
        eng_found = 1'b1;
        eng_index = 5'd7;
        tick(); // c7
        n_cmp++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ack: got %b want 0001", ack);
        end
        n_cmp++;
        if ({eng_start, res_found, res_err} !== 3'b010) begin
            n_fail++;
            $display("FAIL single_result_flags: got start/found/err %b want 010", {eng_start, res_found, res_err});
        end
        n_cmp++;
        if (res_index !== 5'd7) begin
            n_fail++;
            $display("FAIL single_res_index: got %0d want 7", res_index);
        end
        req       = 4'b0000;
        eng_done  = 1'b0;
        eng_found = 1'b0;
        eng_index = 5'd0;
        tick(); // c8 DRAIN
        n_cmp++;
        if ({ack, busy} !== 5'b00001) begin
            n_fail++;
            $display("FAIL single_drain: got ack/busy %b want 00001", {ack, busy});
        end
        tick(); // c9 IDLE
        n_cmp++;
        if ({busy, res_found, res_index} !== {1'b0, 1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL single_held: got busy/found/index %b want 0100111", {busy, res_found, res_index});
        end
    endtask

    task automatic test_timeout();
        int               start_cnt;
        int               ack_at;
        logic             a_bad;
        logic [3:0]       ack_seen;
        logic [6:0]       res_seen;
        start_cnt = 0;
        ack_at    = -1;
        a_bad     = 1'b0;
        ack_seen  = 4'b0000;
        res_seen  = 7'd0;
        target[23:16] = 8'h5A;
        req = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (eng_start === 1'b1) begin
                start_cnt++;
                if (eng_a !== 8'h5A) a_bad = 1'b1;
            end
            if (ack !== 4'b0000) begin
                ack_at   = k;
                ack_seen = ack;
                res_seen = {res_err, res_found, res_index};
                break;
            end
        end
        n_cmp++;
        if (ack_at != 9) begin
            n_fail++;
            $display("FAIL timeout_ack_cycle: got %0d want 9", ack_at);
        end
        n_cmp++;
        if (start_cnt != 8) begin
            n_fail++;
            $display("FAIL timeout_start_cycles: got %0d want 8", start_cnt);
        end
        n_cmp++;
        if (ack_seen !== 4'b0100) begin
            n_fail++;
            $display("FAIL timeout_ack: got %b want 0100", ack_seen);
        end
        n_cmp++;
        if (res_seen !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL timeout_result: got err/found/index %b want 1000000", res_seen);
        end
        n_cmp++;
        if (a_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_eng_a: got bad=%b want 0", a_bad);
        end
        req = 4'b0000;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_back_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_not_found();
        target[15:8] = 8'hFF;
        req = 4'b0010;
        tick(); // c1
        n_cmp++;
        if ({eng_start, eng_a} !== {1'b1, 8'hFF}) begin
            n_fail++;
            $display("FAIL notfound_start: got start/eng_a %b/%h want 1/ff", eng_start, eng_a);
        end
        eng_done  = 1'b1;
        eng_found = 1'b0;
        eng_index = 5'd0;
        tick(); // c2
        n_cmp++;
        if (ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL notfound_ack: got %b want 0010", ack);
        end
        n_cmp++;
        if ({res_found, res_err, res_index} !== 7'd0) begin
            n_fail++;
            $display("FAIL notfound_result: got found/err/index %b want 0000000", {res_found, res_err, res_index});
        end
        eng_done = 1'b0;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_t [4];
        logic [3:0] exp_ack;
        exp_t[0] = 8'h11;
        exp_t[1] = 8'h22;
        exp_t[2] = 8'h33;
        exp_t[3] = 8'h44;
        target = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_ack = 4'b0001 << (i % 4);
            tick(); // RUN
            n_cmp++;
            if ({eng_start, eng_a} !== {1'b1, exp_t[i % 4]}) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got start/eng_a %b/%h want 1/%h", i, eng_start, eng_a, exp_t[i % 4]);
            end
            eng_done  = 1'b1;
            eng_found = 1'b1;
            eng_index = 5'(i + 1);
            tick(); // RESP
            n_cmp++;
            if ({ack, res_index} !== {exp_ack, 5'(i + 1)}) begin
                n_fail++;
                $display("FAIL rr_ack[%0d]: got ack/index %b/%0d want %b/%0d", i, ack, res_index, exp_ack, i + 1);
            end
            eng_done  = 1'b0;
            eng_found = 1'b0;
            tick(); // DRAIN
            tick(); // IDLE
        end
    endtask

    task automatic test_drain();
        tick(); // c1
        n_cmp++;
        if ({eng_start, eng_a} !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL drain_grant1: got start/eng_a %b/%h want 1/22", eng_start, eng_a);
        end
        eng_done  = 1'b1;
        eng_found = 1'b1;
        eng_index = 5'd3;
        tick(); // c2
        n_cmp++;
        if (ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL drain_ack: got %b want 0010", ack);
        end
        for (int k = 3; k <= 5; k++) begin
            tick();
            n_cmp++;
            if ({busy, eng_start, ack} !== 6'b100000) begin
                n_fail++;
                $display("FAIL drain_hold[c%0d]: got busy/start/ack %b want 100000", k, {busy, eng_start, ack});
            end
        end
        eng_done = 1'b0;
        tick(); // c6 IDLE
        n_cmp++;
        if ({busy, eng_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_release: got busy/start %b want 00", {busy, eng_start});
        end
        tick(); // c7
        n_cmp++;
        if ({eng_start, eng_a} !== {1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL drain_grant2: got start/eng_a %b/%h want 1/33", eng_start, eng_a);
        end
        eng_done = 1'b1;
        tick();
        n_cmp++;
        if (ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL drain_ack2: got %b want 0100", ack);
        end
        eng_done = 1'b0;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_search();
        logic saw_ack0;
        saw_ack0 = 1'b0;
        req = 4'b0001;
        tick(); // c1
        tick(); // c2
        tick(); // c3
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({eng_start, busy, ack} !== 6'b000000) begin
            n_fail++;
            $display("FAIL midrst_async: got start/busy/ack %b want 000000", {eng_start, busy, ack});
        end
        n_cmp++;
        if (eng_a !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_eng_a: got %h want 00", eng_a);
        end
        req = 4'b0100;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_early_grant: got start %b want 0", eng_start);
        end
        tick();
        n_cmp++;
        if ({eng_start, eng_a} !== {1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL midrst_regrant: got start/eng_a %b/%h want 1/33", eng_start, eng_a);
        end
        eng_done  = 1'b1;
        eng_found = 1'b1;
        eng_index = 5'd9;
        tick();
        if (ack[0] === 1'b1) saw_ack0 = 1'b1;
        n_cmp++;
        if (ack !== 4'b0100 || saw_ack0) begin
            n_fail++;
            $display("FAIL midrst_ack: got %b want 0100", ack);
        end
        eng_done = 1'b0;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_withdraw();
        req = 4'b0001;
        tick(); // c1
        n_cmp++;
        if ({eng_start, eng_a} !== {1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL withdraw_grant0: got start/eng_a %b/%h want 1/11", eng_start, eng_a);
        end
        req = 4'b1001;
        tick(); // c2
        n_cmp++;
        if (eng_a !== 8'h11) begin
            n_fail++;
            $display("FAIL withdraw_req_change: got eng_a %h want 11", eng_a);
        end
        req = 4'b0001;
        eng_done = 1'b1;
        tick(); // c3
        n_cmp++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL withdraw_ack0: got %b want 0001", ack);
        end
        req = 4'b0010;
        eng_done = 1'b0;
        tick(); // DRAIN
        tick(); // IDLE
        tick(); // RUN
        n_cmp++;
        if ({eng_start, eng_a} !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL withdraw_grant1: got start/eng_a %b/%h want 1/22", eng_start, eng_a);
        end
        eng_done = 1'b1;
        tick();
        n_cmp++;
        if (ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL withdraw_ack1: got %b want 0010", ack);
        end
        eng_done = 1'b0;
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        target    = '0;
        eng_done  = 1'b0;
        eng_found = 1'b0;
        eng_index = 5'd0;
        test_reset();
        test_single();
        test_timeout();
        test_not_found();
        test_round_robin();
        test_drain();
        test_reset_mid_search();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
